// File: rtl/pmod_step_move_ctrl.sv
// pmod_step_move_ctrl: command-driven stepper move sequencer (one step_pulse per step, coil settle after move).
// Optional soft start with STEP_SOFT_START_EN: the first RAMP_STEPS steps of a move use twice the period.
module pmod_step_move_ctrl #(
    parameter int CNT_W         = 16,
    parameter int PER_W         = 24,
    parameter int MIN_PERIOD    = 1000,
    parameter int SETTLE_CYCLES = 100000,
    parameter int RAMP_STEPS    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             motor_en,
    output logic             motor_dir,
    output logic             step_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);
`ifdef STEP_SOFT_START_EN
    localparam int RAMP_N = RAMP_STEPS;
`else
    localparam int RAMP_N = 0;
`endif
    localparam int PW = (RAMP_N > 0) ? PER_W + 1 : PER_W;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int RW = $clog2(RAMP_STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

    state_t           state, nxt;
    logic             live;
    logic [PER_W-1:0] eff;
    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    per_m1;
    logic [SW-1:0]    scnt;
    logic [RW-1:0]    ramp;
    logic             ramp_active;
    logic             accept;

    assign ramp_active = (RAMP_N != 0) && (ramp != RW'(RAMP_N));
    assign per_m1      = (ramp_active ? PW'({eff, 1'b0}) : PW'(eff)) - PW'(1);
    assign accept      = cmd_ready && cmd_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt        = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        motor_en   = 1'b0;
        step_pulse = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = live;
                busy      = 1'b0;
                if (cmd_valid && live)
                    nxt = (cmd_steps == '0) ? DONE : RUN;
            end
            RUN: begin
                motor_en   = 1'b1;
                step_pulse = (pcnt == per_m1);
                if (abort || (step_pulse && steps_left == CNT_W'(1)))
                    nxt = SETTLE;
            end
            SETTLE: begin
                motor_en = 1'b1;
                if (scnt == SW'(SETTLE_CYCLES - 1))
                    nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // live keeps cmd_ready low while reset is asserted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live       <= 1'b0;
            motor_dir  <= 1'b0;
            steps_left <= '0;
            eff        <= '0;
            pcnt       <= '0;
            scnt       <= '0;
            ramp       <= '0;
            aborted    <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                motor_dir  <= cmd_dir;
                steps_left <= cmd_steps;
                eff        <= (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
                pcnt       <= '0;
                scnt       <= '0;
                ramp       <= '0;
                aborted    <= 1'b0;
            end else if (state == RUN) begin
                pcnt <= step_pulse ? '0 : pcnt + PW'(1);
                scnt <= '0;
                if (step_pulse && steps_left != '0)
                    steps_left <= steps_left - CNT_W'(1);
                if (step_pulse && ramp_active)
                    ramp <= ramp + RW'(1);
                if (abort)
                    aborted <= 1'b1;
            end else if (state == SETTLE) begin
                scnt <= scnt + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pmod_step_move_ctrl.sv
// tb_pmod_step_move_ctrl: directed checks of move timing, clamping, abort, reset and settle.
module tb_pmod_step_move_ctrl;
    localparam int MINP   = 20;
    localparam int SETTLE = 30;
`ifdef STEP_SOFT_START_EN
    localparam int RAMP = 8;
`else
    localparam int RAMP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [23:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        motor_en, motor_dir, step_pulse, busy, done, aborted;
    logic [15:0] steps_left;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int np    = 0;
    int nd    = 0;
    int t_prev;

    pmod_step_move_ctrl #(
        .CNT_W(16), .PER_W(24), .MIN_PERIOD(MINP), .SETTLE_CYCLES(SETTLE), .RAMP_STEPS(8)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .motor_en(motor_en),
        .motor_dir(motor_dir), .step_pulse(step_pulse), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (step_pulse) np++;
        if (done) nd++;
    endtask

    // cyc becomes 1 in the cycle after the accepting edge
    task automatic send(input logic dir, input int steps, input int period);
        cmd_dir    = dir;
        cmd_steps  = 16'(steps);
        cmd_period = 24'(period);
        cmd_valid  = 1'b1;
        cyc = 0;
        np  = 0;
        nd  = 0;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pulse();
        int n = 0;
        do begin tick(); n++; end while (!step_pulse && n < 3000);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin tick(); n++; end while (!done && n < 3000);
    endtask

    function automatic int gap(input int k, input int eff);
        return (k <= RAMP) ? 2 * eff : eff;
    endfunction

    initial begin
        // reset held 10 cycles
        repeat (10) tick();
        chk("rst_motor_en", int'(motor_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulse", int'(step_pulse), 0);
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rel_ready", int'(cmd_ready), 1);
        chk("rel_motor_en", int'(motor_en), 0);
        chk("rel_busy", int'(busy), 0);
        chk("rel_done", int'(done), 0);

        // 5 steps forward at the minimum period; cmd_valid while busy is ignored
        send(1'b1, 5, 20);
        chk("t2_motor_en", int'(motor_en), 1);
        chk("t2_busy", int'(busy), 1);
        cmd_valid = 1'b1;
        cmd_steps = 16'd99;
        repeat (3) tick();
        chk("t2_busy_ready", int'(cmd_ready), 0);
        chk("t2_busy_steps", int'(steps_left), 5);
        cmd_valid = 1'b0;
        t_prev = 0;
        for (int k = 1; k <= 5; k++) begin
            wait_pulse();
            t_prev += gap(k, 20);
            chk($sformatf("t2_pulse%0d_cyc", k), cyc, t_prev);
            chk($sformatf("t2_pulse%0d_left", k), int'(steps_left), 6 - k);
            chk($sformatf("t2_pulse%0d_dir", k), int'(motor_dir), 1);
        end
        wait_done();
        chk("t2_done_cyc", cyc, t_prev + SETTLE + 1);
        chk("t2_done_en", int'(motor_en), 0);
        chk("t2_done_abt", int'(aborted), 0);
        chk("t2_npulse", np, 5);
        tick();
        chk("t2_idle_busy", int'(busy), 0);
        chk("t2_idle_ready", int'(cmd_ready), 1);

        // period below minimum is clamped
        send(1'b0, 3, 10);
        t_prev = 0;
        for (int k = 1; k <= 3; k++) begin
            wait_pulse();
            t_prev += gap(k, MINP);
            chk($sformatf("t3_pulse%0d_cyc", k), cyc, t_prev);
            chk($sformatf("t3_pulse%0d_dir", k), int'(motor_dir), 0);
        end
        wait_done();
        chk("t3_done_cyc", cyc, t_prev + SETTLE + 1);
        tick();

        // zero steps: done next cycle, no enable, no pulse
        send(1'b1, 0, 20);
        chk("t3z_done", int'(done), 1);
        chk("t3z_en", int'(motor_en), 0);
        chk("t3z_pulse", int'(step_pulse), 0);
        tick();
        chk("t3z_ready", int'(cmd_ready), 1);
        chk("t3z_nd", nd, 1);

        // abort on the third pulse cycle
        send(1'b1, 10, 20);
        t_prev = 0;
        for (int k = 1; k <= 3; k++) begin
            wait_pulse();
            t_prev += gap(k, 20);
        end
        chk("t4_p3_cyc", cyc, t_prev);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_left", int'(steps_left), 7);
        chk("t4_aborted", int'(aborted), 1);
        chk("t4_settle_en", int'(motor_en), 1);
        wait_done();
        chk("t4_done_cyc", cyc, t_prev + SETTLE + 1);
        chk("t4_done_abt", int'(aborted), 1);
        chk("t4_npulse", np, 3);
        chk("t4_left_end", int'(steps_left), 7);
        tick();

        // reset mid-move after 2 pulses
        send(1'b1, 10, 20);
        wait_pulse();
        wait_pulse();
        repeat (5) tick();
        #1 rst = 1'b0;
        #1;
        chk("t5_en", int'(motor_en), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_left", int'(steps_left), 0);
        chk("t5_dir", int'(motor_dir), 0);
        tick();
        tick();
        #2 rst = 1'b1;
        nd = 0;
        repeat (40) tick();
        chk("t5_no_done", nd, 0);
        chk("t5_ready", int'(cmd_ready), 1);
        send(1'b0, 1, 20);
        wait_pulse();
        chk("t5_new_pulse", cyc, gap(1, 20));
        wait_done();
        chk("t5_new_done", cyc, gap(1, 20) + SETTLE + 1);
        tick();

        // 10 steps: soft-start gaps when enabled, flat otherwise
        send(1'b1, 10, 20);
        t_prev = 0;
        for (int k = 1; k <= 10; k++) begin
            wait_pulse();
            chk($sformatf("t6_gap%0d", k), cyc - t_prev, gap(k, 20));
            t_prev = cyc;
        end
        wait_done();
        chk("t6_done_cyc", cyc, t_prev + SETTLE + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
